float_addsub_pipe: RTL and testbench

Parametrised, 3-stage pipelined adder/subtractor for the lab's unsigned minifloat format. Each operand packs a `{exponent, mantissa}` pair with value = mantissa × 2^exponent; there is no hidden bit and no sign. It generalises the combinational 8-bit float adder in three ways: configurable field widths, a subtract mode with left-normalisation, and valid/ready streaming with backpressure. It sits between operand sources (sequencer, note mixer) and downstream consumers that may stall.

---
 rtl/float_addsub_pipe.sv | 171 +++++++++++++++++
 tb/tb_float_addsub_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/float_addsub_pipe.sv
// Three-stage pipelined add/subtract for the unsigned {exponent, mantissa} minifloat.
// Stages are align, arith and normalise. Valid/ready flow control collapses bubbles.
module float_addsub_pipe #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W-1:0] a,
  input  logic [EXP_W+MAN_W-1:0] b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] result,
  output logic                   ovf,
  output logic                   neg
);

  localparam int W    = EXP_W + MAN_W;
  localparam int LZ_W = $clog2(MAN_W + 1);
  localparam int CW   = (EXP_W > LZ_W) ? EXP_W : LZ_W;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  // Leading-zero count of a nonzero mantissa, written as a priority encoder.
  function automatic logic [CW-1:0] lead_zeros(input logic [MAN_W-1:0] x);
    lead_zeros = CW'(MAN_W);
    for (int i = 0; i < MAN_W; i++) begin
      if (x[i]) lead_zeros = CW'(MAN_W - 1 - i);
    end
  endfunction

  // Pipeline state
  logic             v1, v2, v3;
  logic [EXP_W-1:0] emax1, emax2;
  logic [MAN_W-1:0] a_al1, b_al1;
  op_e              op1, op2;
  logic [MAN_W:0]   arith2;
  logic             neg2;

  // Flow control: a stage loads when it is empty or its occupant moves on.
  logic en1, en2, en3;
  assign en3       = !v3 || out_ready;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  // ---------------- S1: align ----------------
  logic [EXP_W-1:0] ea, eb, emax_c;
  logic [MAN_W-1:0] ma, mb, a_al_c, b_al_c;

  always_comb begin
    ea     = a[W-1:MAN_W];
    eb     = b[W-1:MAN_W];
    ma     = a[MAN_W-1:0];
    mb     = b[MAN_W-1:0];
    emax_c = (ea >= eb) ? ea : eb;
    // A logical shift by MAN_W or more already yields zero.
    a_al_c = ma >> (emax_c - ea);
    b_al_c = mb >> (emax_c - eb);
  end

  // NOTE: clocked state uses non-blocking assignments so every stage samples
  // the pre-edge value of the stage before it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1    <= 1'b0;
      emax1 <= '0;
      a_al1 <= '0;
      b_al1 <= '0;
      op1   <= OP_ADD;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) begin
        emax1 <= emax_c;
        a_al1 <= a_al_c;
        b_al1 <= b_al_c;
        op1   <= op_e'(op);
      end
    end
  end

  // ---------------- S2: arith ----------------
  logic [MAN_W:0] arith_c;
  logic           neg_c;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    arith_c = '0;
    neg_c   = 1'b0;
    if (op1 == OP_ADD) begin
      arith_c = {1'b0, a_al1} + {1'b0, b_al1};
    end else if (a_al1 >= b_al1) begin
      arith_c = {1'b0, a_al1 - b_al1};
    end else begin
      neg_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2     <= 1'b0;
      emax2  <= '0;
      arith2 <= '0;
      neg2   <= 1'b0;
      op2    <= OP_ADD;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        emax2  <= emax1;
        arith2 <= arith_c;
        neg2   <= neg_c;
        op2    <= op1;
      end
    end
  end

  // ---------------- S3: normalise ----------------
  logic [MAN_W-1:0] diff;
  logic [CW-1:0]    lz, k;
  logic [EXP_W-1:0] exp_inc;
  logic [W-1:0]     res_c;
  logic             ovf_c, negr_c;

  always_comb begin
    diff    = arith2[MAN_W-1:0];
    lz      = lead_zeros(diff);
    k       = (lz < CW'(emax2)) ? lz : CW'(emax2);
    exp_inc = emax2 + EXP_W'(1);
    res_c   = '0;
    ovf_c   = 1'b0;
    negr_c  = 1'b0;
    if (op2 == OP_ADD) begin
      if (!arith2[MAN_W]) begin
        res_c = {emax2, diff};
      end else if (emax2 != EXP_MAX) begin
        res_c = {exp_inc, arith2[MAN_W:1]};
      end else begin
        res_c = '1;
        ovf_c = 1'b1;
      end
    end else begin
      negr_c = neg2;
      // A negative difference was already forced to zero in S2.
      if (diff != '0) begin
        res_c = {emax2 - EXP_W'(k), diff << k};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3     <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      neg    <= 1'b0;
    end else if (en3) begin
      v3 <= v2;
      if (v2) begin
        result <= res_c;
        ovf    <= ovf_c;
        neg    <= negr_c;
      end
    end
  end

endmodule

// File: tb/tb_float_addsub_pipe.sv
// Bench for float_addsub_pipe: directed vectors, backpressure, reset, and a
// randomized streaming run scored against a value-level reference model.
module tb_float_addsub_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, op;
  logic [7:0] a, b, result;
  logic       out_valid, out_ready, ovf, neg;

  float_addsub_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .neg(neg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic       ovf;
    logic       neg;
  } exp_t;

  typedef struct {
    logic [7:0] a, b;
    logic       op;
    logic [7:0] res;
    logic       ovf, neg;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Value-level model: operate on plain integers, normalise by doubling.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic sub);
    int ea, eb, e, xa, xb, m;
    exp_t r;
    ea = int'(x[7:5]); eb = int'(y[7:5]);
    e  = (ea > eb) ? ea : eb;
    xa = int'(x[4:0]) / (1 << (e - ea));
    xb = int'(y[4:0]) / (1 << (e - eb));
    r  = '0;
    if (!sub) begin
      m = xa + xb;
      if (m >= 32) begin
        if (e == 7) begin
          r.res = 8'hFF; r.ovf = 1'b1;
          return r;
        end
        e = e + 1; m = m / 2;
      end
      r.res = {3'(e), 5'(m)};
    end else if (xa < xb) begin
      r.neg = 1'b1;
    end else begin
      m = xa - xb;
      if (m != 0) begin
        while (m < 16 && e > 0) begin
          m = m * 2; e = e - 1;
        end
        r.res = {3'(e), 5'(m)};
      end
    end
    return r;
  endfunction

  // Output monitor: every drained result must match the model, in order.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("ovf_neg_exclusive", {31'b0, ovf & neg}, 0);
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("stream_result", result, e.res);
          check("stream_ovf", ovf, e.ovf);
          check("stream_neg", neg, e.neg);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, op));
    end
  end

  vec_t vecs[10];
  exp_t bp_exp[4];
  int   sent, cyc;
  logic acc;

  initial begin
    vecs[0] = '{8'h50, 8'h04, 1'b0, 8'h51, 1'b0, 1'b0};
    vecs[1] = '{8'h38, 8'h28, 1'b0, 8'h50, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 8'hE1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h70, 8'h6F, 1'b1, 8'h08, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 8'h02, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{8'h21, 8'h21, 1'b0, 8'h22, 1'b0, 1'b0};
    vecs[6] = '{8'h60, 8'h60, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'h1F, 8'hE1, 1'b0, 8'hE1, 1'b0, 1'b0};
    vecs[8] = '{8'h23, 8'h22, 1'b1, 8'h02, 1'b0, 1'b0};
    vecs[9] = '{8'hDF, 8'hC1, 1'b0, 8'hF0, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_ovf", ovf, 0);
    check("reset_neg", neg, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #1 reset = 1'b0;

    // Directed vectors, one at a time, with latency check.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; in_valid = 1'b1; out_ready = 1'b1;
      check("vec_in_ready", in_ready, 1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1;
      check("vec_early_valid", out_valid, 0);
      @(posedge clk); #1;
      check("vec_out_valid", out_valid, 1);
      check("vec_result", result, vecs[i].res);
      check("vec_ovf", ovf, vecs[i].ovf);
      check("vec_neg", neg, vecs[i].neg);
    end

    // Backpressure: three fill the pipe, the fourth is refused until release.
    @(posedge clk); #1 out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      a = vecs[j].a; b = vecs[j].b; op = vecs[j].op; in_valid = 1'b1;
      bp_exp[j] = model(vecs[j].a, vecs[j].b, vecs[j].op);
      check("bp_in_ready", in_ready, (j < 3) ? 1 : 0);
      @(posedge clk); #1;
    end
    for (int j = 0; j < 2; j++) begin
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_result", result, bp_exp[0].res);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      @(posedge clk); #1;
      if (j == 1) in_valid = 1'b0;
      check("bp_drain_valid", out_valid, 1);
      check("bp_drain_result", result, bp_exp[j].res);
      check("bp_drain_ovf", ovf, bp_exp[j].ovf);
    end
    @(posedge clk); #1;
    check("bp_empty", out_valid, 0);

    // Reset with items in flight.
    out_ready = 1'b0;
    a = 8'h50; b = 8'h04; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 a = 8'h38; b = 8'h28;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    a = 8'h21; b = 8'h21; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_first_early", out_valid, 0);
    @(posedge clk); #1;
    check("rst_first_valid", out_valid, 1);
    check("rst_first_result", result, 8'h22);
    @(posedge clk); #1;
    check("rst_no_stale", out_valid, 0);

    // Randomized streaming with random bubbles on both sides.
    sent = 0; cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      @(negedge clk) acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      if (!in_valid && sent < 1000 && $urandom_range(1, 0) == 1) begin
        a = 8'($urandom); b = 8'($urandom); op = 1'($urandom); in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(1, 0));
    end
    check("rand_accepted", sent, 1000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
    @(posedge clk); #1;
    check("rand_drained", sb.size(), 0);
    check("rand_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
